txuart_cfg: RTL
===============

# txuart_cfg

Parametrised UART transmitter, next generation of the team's fixed 8N1 transmitter. It supports configurable data width, parity mode and stop-bit count, and adds a line-break generator and a one-cycle frame-done pulse. It sits between a byte producer (bus bridge, FIFO or command sequencer) and the board TX pin, and is driven by the system clock through a fixed baud divider.

## Interface
- CLOCKS_PER_BAUD, 24'd68: system clocks per bit period. Legal range is 2 or more.
- DATA_BITS, 8: data bits per frame. Legal range is 5 to 9.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even. Value 3 is illegal.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- i_clk, input, 1: system clock. All logic is on the rising edge.
- i_reset, input, 1: asynchronous, active-high reset.
- i_wr, input, 1: write request. Qualified as described under Operation.
- i_data, input, DATA_BITS: word to send, LSB first.
- i_break, input, 1: break request. Holds the line low while asserted.
- o_busy, output, 1: registered. Low only in IDLE.
- o_uart_tx, output, 1: registered serial line. Idles high.
- o_done, output, 1: registered. One-cycle pulse when a data frame completes.

## Operation
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-high.
- Reset values:
  - o_uart_tx = 1, o_busy = 0, o_done = 0.
  - State = IDLE, baud counter = CLOCKS_PER_BAUD - 1, bit counter = 0.
- Reset asserted mid-frame: the line goes high immediately (asynchronously) and the frame is abandoned. No o_done is produced.
- States: IDLE, START, DATA, PARITY, STOP, BREAK, GUARD.
- Acceptance:
  - A write is accepted on a rising edge where i_wr=1, o_busy=0 and i_break=0.
  - i_data is latched into the shift register on that edge.
  - Parity is computed from i_data on that same edge.
- IDLE:
  - i_break=1 goes to BREAK. Break has priority over i_wr, and the write is not accepted; the producer must hold i_wr.
  - An accepted write goes to START.
- START: line 0 for one bit period, then DATA.
- DATA:
  - DATA_BITS bit periods, LSB first. The register shifts right at each bit boundary.
  - Then PARITY if PARITY != 0, otherwise STOP.
- PARITY: one bit period.
  - Odd mode: the bit makes the total count of ones (data plus parity) odd.
  - Even mode: the total count is even.
- STOP:
  - STOP_BITS bit periods of line 1.
  - Then IDLE, with o_done=1 and o_busy=0 on that same edge.
- BREAK:
  - Line 0, o_busy=1, for as long as i_break=1, with a minimum of one bit period.
  - On exit, go to GUARD.
- GUARD:
  - Line 1 for STOP_BITS bit periods, then IDLE.
  - No o_done.
- i_break during a frame: ignored until IDLE. The frame always completes.
- i_wr while o_busy=1: ignored. No queueing.
- i_data is ignored except on the accepting edge.

## Timing
- Bit period:
  - Every bit, including start, parity, stop and break, lasts exactly CLOCKS_PER_BAUD cycles.
  - The counter reloads to CLOCKS_PER_BAUD - 1 at each bit boundary and at acceptance.
- Frame length: N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits.
- Write accepted on edge E0:
  - o_uart_tx=0 and o_busy=1 are visible from E0.
  - The LSB appears at edge E0 + CLOCKS_PER_BAUD.
  - o_busy falls and o_done pulses at edge E0 + N·CLOCKS_PER_BAUD.
- Back-to-back writes (i_wr held high):
  - The next write is accepted at E0 + N·CLOCKS_PER_BAUD + 1.
  - The line therefore stays high for STOP_BITS·CLOCKS_PER_BAUD + 1 cycles between frames.
- o_done: high for exactly one cycle per completed data frame.
- Break:
  - Line low from the edge sampling i_break=1 in IDLE.
  - The line rises max(CLOCKS_PER_BAUD, break length) cycles later, rounded up to the bit boundary following i_break deassertion.
  - o_busy stays high through GUARD.
- Counter width: 24-bit. The count must not wrap. CLOCKS_PER_BAUD = 24'hFFFFFF must give exact bit periods.

## Test plan
- 8N1 frame: CLOCKS_PER_BAUD=4, DATA_BITS=8, PARITY=0, STOP_BITS=1. Write 8'hA5 -> line bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles. o_busy high for exactly 40 cycles, then o_done pulses once.
- 7E2 frame: DATA_BITS=7, PARITY=2, STOP_BITS=2. Write 7'h41 -> bits 0,1,0,0,0,0,0,1,0,1,1. The parity bit is 0 (two ones, even). Frame is 11·CLOCKS_PER_BAUD cycles.
- 9O1 frame: DATA_BITS=9, PARITY=1. Write 9'h1FF -> parity bit 0 (nine ones, already odd). Write 9'h000 -> parity bit 1.
- Back-to-back: hold i_wr=1 with 8'h00, then 8'hFF -> second start edge is exactly 40·... 10·CLOCKS_PER_BAUD + 1 cycles after the first. Exactly two o_done pulses. No write is accepted while busy.
- Break: with i_break=1 and i_wr=1 for 2 cycles (CLOCKS_PER_BAUD=4):
  - Line low for 4 cycles, then high for 4 GUARD cycles. No o_done.
  - The write is accepted only after o_busy falls.
- Reset mid-frame: assert i_reset during DATA bit 3 -> o_uart_tx=1 and o_busy=0 immediately. After release, a fresh write of 8'h3C produces a clean full frame.

Source files
------------

// File: rtl/txuart_cfg.sv
// Configurable UART transmitter: DATA_BITS data bits, optional odd/even parity,
// 1 or 2 stop bits, a line-break generator and a one-cycle frame-done pulse.
module txuart_cfg #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd68,
  parameter int          DATA_BITS       = 8,
  parameter int          PARITY          = 0,
  parameter int          STOP_BITS       = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_break,
  output logic                 o_busy,
  output logic                 o_uart_tx,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP,
    BREAK,
    GUARD
  } state_t;

  localparam logic [23:0] BAUD_RELOAD = CLOCKS_PER_BAUD - 24'd1;
  localparam logic [3:0]  LAST_DATA   = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP   = 4'(STOP_BITS - 1);
  localparam bit          HAS_PARITY  = (PARITY != 0);
  localparam bit          ODD_PARITY  = (PARITY == 1);

  state_t               state, state_n;
  logic [23:0]          baud_cnt, baud_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_n;
  logic                 tx_n, busy_n, done_n;
  logic                 baud_tick;

  // The counter only ever counts down to zero and reloads, so it never wraps
  // even with the largest divider.
  assign baud_tick = (baud_cnt == 24'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      baud_cnt  <= BAUD_RELOAD;
      bit_cnt   <= 4'd0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      o_uart_tx <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      par_bit   <= par_n;
      o_uart_tx <= tx_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
    end
  end

  // Outputs are computed one edge ahead so the line changes exactly on the
  // bit boundary edge.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_bit;
    tx_n    = o_uart_tx;
    busy_n  = o_busy;
    done_n  = 1'b0;

    if (state != IDLE) begin
      baud_n = baud_tick ? BAUD_RELOAD : (baud_cnt - 24'd1);
    end

    case (state)
      IDLE: begin
        baud_n = BAUD_RELOAD;
        bit_n  = 4'd0;
        tx_n   = 1'b1;
        busy_n = 1'b0;
        // Break wins over a pending write; the producer keeps i_wr asserted.
        if (i_break) begin
          state_n = BREAK;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end else if (i_wr) begin
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          shreg_n = i_data;
          par_n   = ODD_PARITY ? ~(^i_data) : (^i_data);
        end
      end
      START: begin
        if (baud_tick) begin
          state_n = DATA;
          bit_n   = 4'd0;
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt == LAST_DATA) begin
            bit_n = 4'd0;
            if (HAS_PARITY) begin
              state_n = PARITY_BIT;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n   = bit_cnt + 4'd1;
            tx_n    = shreg[0];
            shreg_n = shreg >> 1;
          end
        end
      end
      PARITY_BIT: begin
        if (baud_tick) begin
          state_n = STOP;
          bit_n   = 4'd0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (bit_cnt == LAST_STOP) begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end
      end
      BREAK: begin
        // Release is only checked on bit boundaries, giving a whole number of
        // bit periods of break.
        if (baud_tick && !i_break) begin
          state_n = GUARD;
          bit_n   = 4'd0;
          tx_n    = 1'b1;
        end
      end
      GUARD: begin
        if (baud_tick) begin
          if (bit_cnt == LAST_STOP) begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
